lms_step_shifter: RTL

- Parametrised, pipelined arithmetic right shifter that forms the power-of-two step-size term for the sign-sign LMS weight-update path of the adaptive filter.
- Computes o = gate ? ±round(w >>> (BASE + sh)) : 0, with optional negation and saturation.
- Sits between the error/data sign logic and the weight accumulator.
- Valid/ready handshake on input and output, so the weight-update loop can stall it.

---
 rtl/lms_pkg.sv | 30 +++
 rtl/lms_shift_stage.sv | 70 +++++++
 rtl/lms_step_shifter.sv | 114 +++++++++++
 3 files changed

// File: rtl/lms_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lms_pkg : shared defaults, per-stage control record and negate helper    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package lms_pkg;

  localparam int LMS_W_DEF    = 10;
  localparam int LMS_S_DEF    = 3;
  localparam int LMS_BASE_DEF = 1;
  localparam int LMS_WMAX     = 32;

  typedef logic signed [LMS_WMAX-1:0] lms_wide_t;

  typedef struct packed {
    logic valid;
    logic rbit;
    logic neg;
    logic rnd;
  } lms_ctl_t;

  // Negating the most negative W-bit value is the only case that must saturate.
  function automatic logic lms_neg_ovf(input lms_wide_t x, input int unsigned width);
    lms_wide_t v_min;
    v_min = -(lms_wide_t'(1) <<< (width - 1));
    return (x == v_min);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lms_shift_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lms_shift_stage : one registered arithmetic shift-by-2^K stage           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lms_shift_stage
  import lms_pkg::*;
#(
  parameter int W = LMS_W_DEF,
  parameter int K = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_sel,
  input  logic signed [W-1:0] i_data,
  input  lms_ctl_t            i_ctl,
  output logic signed [W-1:0] o_data,
  output lms_ctl_t            o_ctl
);

  localparam int SHAMT = 2 ** K;

  logic [K:0]          r_sel_dly;
  logic [K:0]          w_sel_next;
  logic signed [W-1:0] r_data;
  lms_ctl_t            r_ctl;
  logic signed [W-1:0] w_shifted;
  logic                w_out_bit;
  logic                w_sel;

  // The select bit travels alongside its beat: K+1 advances after acceptance.
  generate
    if (K == 0) begin : g_dly0
      assign w_sel_next = i_sel;
    end else begin : g_dlyn
      assign w_sel_next = {r_sel_dly[K-1:0], i_sel};
    end
  endgenerate

  generate
    if (SHAMT >= W) begin : g_sat
      assign w_shifted = {W{i_data[W-1]}};
      assign w_out_bit = i_data[W-1];
    end else begin : g_norm
      assign w_shifted = i_data >>> SHAMT;
      assign w_out_bit = i_data[SHAMT-1];
    end
  endgenerate

  assign w_sel = r_sel_dly[K];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl.valid <= 1'b0;
    end else if (i_en) begin
      r_sel_dly   <= w_sel_next;
      r_data      <= w_sel ? w_shifted : i_data;
      r_ctl.valid <= i_ctl.valid;
      r_ctl.neg   <= i_ctl.neg;
      r_ctl.rnd   <= i_ctl.rnd;
      r_ctl.rbit  <= w_sel ? w_out_bit : i_ctl.rbit;
    end
  end

  assign o_data = r_data;
  assign o_ctl  = r_ctl;

endmodule
`default_nettype wire

// File: rtl/lms_step_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lms_step_shifter : pipelined gated/rounded/negated power-of-two shifter  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lms_step_shifter
  import lms_pkg::*;
#(
  parameter int W    = LMS_W_DEF,
  parameter int S    = LMS_S_DEF,
  parameter int BASE = LMS_BASE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] w,
  input  logic [S-1:0]        sh,
  input  logic                gate,
  input  logic                neg,
  input  logic                rnd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] o,
  output logic                ovf
);

  logic                w_en;
  logic signed [W-1:0] w_gated;
  logic signed [W-1:0] w_p0_data;
  logic                w_p0_rbit;
  logic signed [W-1:0] r_p0_data;
  lms_ctl_t            r_p0_ctl;
  logic signed [W-1:0] w_data [0:S];
  lms_ctl_t            w_ctl  [0:S];
  logic                w_rnd_add;
  logic signed [W-1:0] w_rounded;
  logic                w_neg_ovf;
  logic signed [W-1:0] w_negated;
  logic                r_out_valid;
  logic signed [W-1:0] r_o;
  logic                r_ovf;

  assign w_en     = !(r_out_valid && !out_ready);
  assign in_ready = w_en;
  assign w_gated  = gate ? w : '0;

  generate
    if (BASE == 0) begin : g_base_none
      assign w_p0_data = w_gated;
      assign w_p0_rbit = 1'b0;
    end else begin : g_base_shift
      assign w_p0_data = w_gated >>> BASE;
      assign w_p0_rbit = w_gated[BASE-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_ctl.valid <= 1'b0;
    end else if (w_en) begin
      r_p0_data      <= w_p0_data;
      r_p0_ctl.valid <= in_valid;
      r_p0_ctl.rbit  <= w_p0_rbit;
      r_p0_ctl.neg   <= neg;
      r_p0_ctl.rnd   <= rnd;
    end
  end

  assign w_data[0] = r_p0_data;
  assign w_ctl[0]  = r_p0_ctl;

  generate
    for (genvar k = 0; k < S; k++) begin : g_stage
      lms_shift_stage #(
        .W (W),
        .K (k)
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_en),
        .i_sel  (sh[k]),
        .i_data (w_data[k]),
        .i_ctl  (w_ctl[k]),
        .o_data (w_data[k+1]),
        .o_ctl  (w_ctl[k+1])
      );
    end
  endgenerate

  // A set round bit implies the shifted magnitude is small, so this add cannot wrap.
  assign w_rnd_add = w_ctl[S].rnd & w_ctl[S].rbit;
  assign w_rounded = w_data[S] + $signed({{(W-1){1'b0}}, w_rnd_add});
  assign w_neg_ovf = lms_neg_ovf(lms_wide_t'(w_rounded), W);
  assign w_negated = w_neg_ovf ? $signed({1'b0, {(W-1){1'b1}}}) : -w_rounded;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_o         <= '0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= w_ctl[S].valid;
      r_o         <= w_ctl[S].neg ? w_negated : w_rounded;
      r_ovf       <= w_ctl[S].neg & w_neg_ovf;
    end
  end

  assign out_valid = r_out_valid;
  assign o         = r_o;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire
